// File: rtl/mul16_seq.sv
// Sequential 16x16 signed multiplier (shift-and-add, one multiplier bit per cycle).
// Returns the low 16 product bits plus a signed-overflow flag after a 16-cycle RUN phase.
module mul16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        overflow
);

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_sign_bit;
    logic          w_last;
    logic [AW-1:0] w_addend;
    logic [AW-1:0] w_acc_next;
    logic          w_ovf_next;

    // Partial-product step; the MSB of b carries weight -2^15, hence the subtract.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && start;
        w_sign_bit = (r_cnt == CW'(W - 1));
        w_last     = (r_state == S_RUN) && w_sign_bit;
        w_addend   = {{W{r_a[W-1]}}, r_a} << r_cnt;
        w_acc_next = r_acc;
        if (r_b[r_cnt]) begin
            if (w_sign_bit) begin
                w_acc_next = r_acc - w_addend;
            end else begin
                w_acc_next = r_acc + w_addend;
            end
        end
        w_ovf_next = !((&w_acc_next[AW-1:W-1]) || !(|w_acc_next[AW-1:W-1]));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_sign_bit) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            busy    <= (w_state_next == S_RUN);
            done    <= (w_state_next == S_DONE);
        end
    end

    // Operand capture, accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_last) begin
                product  <= w_acc_next[W-1:0];
                overflow <= w_ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed testbench for mul16_seq: hand-computed products, latency, busy length,
// start-ignored-in-RUN, back-to-back starts and mid-operation reset.
module tb_mul16_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    mul16_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check busy length, done timing and the result.
    task automatic run_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic [15:0] ep, input logic eo);
        int n;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd16);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_product"}, 32'(product), 32'(ep));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int n_done;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_mul("m3x4",    16'd3,      16'd4,      16'd12,    1'b0);
        run_mul("mn2x3",   16'hFFFE,   16'd3,      16'hFFFA,  1'b0);
        run_mul("m181",    16'd181,    16'd181,    16'd32761, 1'b0);
        run_mul("m182",    16'd182,    16'd182,    16'h8164,  1'b1);
        run_mul("mmin_x1", 16'h8000,   16'd1,      16'h8000,  1'b0);
        run_mul("mmin_xn1",16'h8000,   16'hFFFF,   16'h8000,  1'b1);
        run_mul("m256",    16'd256,    16'd256,    16'h0000,  1'b1);

        // start during RUN is ignored and operand changes do not leak in
        @(negedge clk);
        a = 16'd5;
        b = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'd9;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        check("ign_done_pulses", 32'(n_done), 32'd1);
        check("ign_product", 32'(product), 32'd35);
        check("ign_busy_idle", 32'(busy), 32'd0);

        // start held high: a new operation every 18 cycles
        a = 16'd3;
        b = 16'd5;
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("b2b_first_done", 32'(done), 32'd1);
        @(negedge clk);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("b2b_interval", 32'(n), 32'd18);
        check("b2b_product", 32'(product), 32'd15);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);

        // reset 8 cycles after acceptance aborts the operation
        a = 16'd11;
        b = 16'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_mul("post_rst", 16'd2, 16'd2, 16'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 16 bits, Hack word width.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  16  signed two's-complement multiplicand, captured on acceptance.
REQ-006 b  input  16  signed two's-complement multiplier, captured on acceptance.
REQ-007 busy  output  1  high while an operation is in progress (RUN state).
REQ-008 done  output  1  single-cycle pulse; product and overflow are valid for the new result.
REQ-009 product  output  16  low 16 bits of the signed product a*b.
REQ-010 overflow  output  1  high when the full signed product is outside -32768..32767.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE, held in registers.
REQ-012 IDLE with start=1 at a rising edge (acceptance edge) SHALL capture a and b, clear the 32-bit accumulator and iteration count, and enter RUN.
REQ-013 IDLE with start=0 SHALL remain in IDLE with all outputs held.
REQ-014 RUN SHALL process exactly one multiplier bit per cycle, LSB first, for 16 cycles (count 0..15).
  - Bits 0..14: add the sign-extended, shifted multiplicand to the accumulator when the bit is 1.
  - Bit 15: subtract it when the bit is 1 (two's-complement weight -2^15).
REQ-015 After count 15, RUN SHALL enter DONE; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-016 busy SHALL be 1 exactly while in RUN, for 16 cycles; done SHALL be 1 exactly while in DONE, for 1 cycle.
REQ-017 Latency: done SHALL be high in the cycle following the 17th rising edge counted from and including the acceptance edge.
REQ-018 product SHALL equal accumulator[15:0].
REQ-019 overflow SHALL be 1 iff accumulator[31:15] is neither all 0s nor all 1s.
REQ-020 product and overflow SHALL update only on the edge entering DONE, and SHALL hold until the next entry into DONE.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-022 With start held high continuously, a new operation SHALL be accepted every 18 cycles.
REQ-023 Changes to a or b after the acceptance edge SHALL NOT affect the result.
REQ-024 Arithmetic SHALL be modulo 2^32 internally; product SHALL wrap modulo 2^16 with no saturation.
  - -32768 * -1 yields product 16'h8000 with overflow=1.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, busy=0, done=0, product=16'h0000, overflow=0, and clear the accumulator, count and captured operands.
REQ-026 rst asserted mid-operation SHALL abort it without a done pulse.
REQ-027 After rst deasserts, the first start seen at a rising edge SHALL be accepted normally.

Verification
REQ-028 a=3, b=4, start for 1 cycle -> busy high for 16 cycles, done pulse at acceptance+17, product=16'd12, overflow=0.
REQ-029 a=-2, b=3 -> product=16'hFFFA, overflow=0.
REQ-030 a=181, b=181 -> product=16'd32761, overflow=0; a=182, b=182 -> product=16'h8164, overflow=1.
REQ-031 a=-32768, b=1 -> product=16'h8000, overflow=0; a=-32768, b=-1 -> product=16'h8000, overflow=1; a=256, b=256 -> product=16'h0000, overflow=1.
REQ-032 Accept a=5, b=7, then in the next cycle set a=9 and pulse start during RUN -> that start is ignored, product=16'd35, exactly one done pulse.
REQ-033 Assert rst 8 cycles after acceptance -> busy=0, product=0 immediately, no done pulse; a following start with a=2, b=2 yields product=16'd4.
